alu_cmd_pipe: RTL and testbench

//  Registered command/result stage wrapped around the combinational SimpleALU.

---
 rtl/alu_cmd_pipe_pkg.sv | 20 ++
 rtl/alu_cmd_pipe_if.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_cmd_pipe.sv | 97 +++++++++
 tb/tb_alu_cmd_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_pipe_pkg.sv
// Shared opcode encoding and small helpers for the ALU command/result pipe.
package alu_cmd_pipe_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_MUL = 2'b10,
        ALU_INC = 2'b11
    } alu_op_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_CNT_WIDTH = 16;

    // The result register can take a new value when it is empty or being drained now.
    function automatic logic stage_free(input logic res_valid, input logic res_ready);
        return (!res_valid) || res_ready;
    endfunction

endpackage

// File: rtl/alu_cmd_pipe_if.sv
// Command, ALU-side and result signals of the ALU command pipe grouped as one bundle.
interface alu_cmd_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIDTH-1:0]     cmd_a;
    logic [WIDTH-1:0]     cmd_b;
    logic [1:0]           cmd_sel;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [1:0]           alu_sel;
    logic [2*WIDTH-1:0]   alu_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_data;
    logic [1:0]           res_sel;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is visible combinationally.
module alu_cmd_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_wdata,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_pipe.sv
// Buffers ALU commands in a FIFO, presents the head to an external ALU and
// captures its output into a result register with valid/ready backpressure.
module alu_cmd_pipe
    import alu_cmd_pipe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    alu_cmd_pipe_if.slave           bus,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic [CNT_WIDTH-1:0]    o_op_count
);
    localparam int DW = 2*WIDTH + 2;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_issue;
    logic [DW-1:0]        w_wdata;
    logic [DW-1:0]        w_head;
    logic [WIDTH-1:0]     w_head_a;
    logic [WIDTH-1:0]     w_head_b;
    logic [1:0]           w_head_sel;

    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_data;
    logic [1:0]           r_res_sel;
    logic [CNT_WIDTH-1:0] r_op_count;

    // A full FIFO refuses commands even if an entry frees at the same edge.
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_issue = !w_empty && stage_free(r_res_valid, bus.res_ready);
    assign w_wdata = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};

    alu_cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_issue),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // Head entry towards the ALU, forced to zero while nothing is buffered.
    always_comb begin
        w_head_a   = '0;
        w_head_b   = '0;
        w_head_sel = 2'b00;
        if (!w_empty) begin
            w_head_a   = w_head[DW-1 -: WIDTH];
            w_head_b   = w_head[WIDTH+1 -: WIDTH];
            w_head_sel = w_head[1:0];
        end else begin
            w_head_a   = '0;
            w_head_b   = '0;
            w_head_sel = 2'b00;
        end
    end

    // Result register and completed-operation counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= 2'b00;
            r_op_count  <= '0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.alu_out;
            r_res_sel   <= w_head_sel;
            r_op_count  <= r_op_count + CNT_WIDTH'(1);
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.alu_a     = w_head_a;
    assign bus.alu_b     = w_head_b;
    assign bus.alu_sel   = w_head_sel;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_sel   = r_res_sel;
    assign o_op_count    = r_op_count;

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Directed bench for alu_cmd_pipe with an attached reference ALU and a result scoreboard.
module tb_alu_cmd_pipe;
    import alu_cmd_pipe_pkg::*;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int CW  = 4;

    logic           clk;
    logic           rst;
    logic [2:0]     level;
    logic [CW-1:0]  op_count;

    int tests_run = 0;
    int fails     = 0;
    int n_pops    = 0;
    logic [17:0] sb [$];

    alu_cmd_pipe_if #(.WIDTH(W)) bus ();

    alu_cmd_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_level    (level),
        .o_op_count (op_count)
    );

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] s);
        case (s)
            2'b00:   return {8'h00, a} + {8'h00, b};
            2'b01:   return {8'h00, a & b};
            2'b10:   return {8'h00, a} * {8'h00, b};
            default: return {8'h00, a} + 16'd1;
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on result handshake, push on command handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.res_valid && bus.res_ready) begin
                tests_run++;
                n_pops++;
                if (sb.size() == 0) begin
                    fails++;
                    $error("FAIL sb_unexpected: observed %0h expected none",
                           {bus.res_sel, bus.res_data});
                end else begin
                    automatic logic [17:0] e = sb.pop_front();
                    assert ({bus.res_sel, bus.res_data} === e) else begin
                        fails++;
                        $error("FAIL sb_result: observed %0h expected %0h",
                               {bus.res_sel, bus.res_data}, e);
                    end
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                sb.push_back({bus.cmd_sel, alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_sel)});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        logic acc;
        acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = s;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (!bus.res_valid && level == 3'd0) begin
                idle = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_sel   = 2'b00;
        bus.res_ready = 1'b1;
        rst           = 1'b1;

        // 1: reset
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_alu_a_zero", {24'd0, bus.alu_a}, 32'd0);

        // 2: single op
        send(8'd5, 8'd15, ALU_ADD);
        check("single_no_bypass", {31'd0, bus.res_valid}, 32'd0);
        cycle();
        check("single_valid", {31'd0, bus.res_valid}, 32'd1);
        check("single_data", {16'd0, bus.res_data}, 32'd20);
        check("single_sel", {30'd0, bus.res_sel}, 32'd0);
        cycle();
        check("single_drained", {31'd0, bus.res_valid}, 32'd0);
        check("single_count", {28'd0, op_count}, 32'd1);

        // 3: back-to-back, one result per cycle
        send(8'd7, 8'd13, ALU_ADD);
        send(8'd7, 8'd13, ALU_AND);
        check("b2b_r0", {16'd0, bus.res_data}, 32'd20);
        send(8'd7, 8'd13, ALU_MUL);
        check("b2b_r1", {16'd0, bus.res_data}, 32'd5);
        send(8'd7, 8'd13, ALU_INC);
        check("b2b_r2", {16'd0, bus.res_data}, 32'd91);
        cycle();
        check("b2b_r3", {16'd0, bus.res_data}, 32'd8);
        check("b2b_r3_sel", {30'd0, bus.res_sel}, 32'd3);
        wait_idle();
        check("b2b_count", {28'd0, op_count}, 32'd5);

        // 4: backpressure and fill
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'(i + 1), 8'(3 * i + 2), 2'(i));
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'd200;
        bus.cmd_b     = 8'd3;
        bus.cmd_sel   = ALU_MUL;
        cycle();
        cycle();
        cycle();
        check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("full_level", {29'd0, level}, 32'd4);
        check("full_res_valid", {31'd0, bus.res_valid}, 32'd1);
        check("full_res_held", {16'd0, bus.res_data}, 32'd3);
        pops0 = n_pops;
        bus.res_ready = 1'b1;
        send(8'd200, 8'd3, ALU_MUL);
        wait_idle();
        check("drain_count", n_pops - pops0, 32'd6);
        check("drain_op_count", {28'd0, op_count}, 32'd11);

        // 5: reset mid-operation
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'd9, 8'(i), ALU_ADD);
        end
        check("pre_rst_level", {29'd0, level}, 32'd3);
        check("pre_rst_valid", {31'd0, bus.res_valid}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid_rst_data", {16'd0, bus.res_data}, 32'd0);
        check("mid_rst_count", {28'd0, op_count}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.res_ready = 1'b1;
        send(8'd1, 8'd1, ALU_MUL);
        cycle();
        check("post_rst_data", {16'd0, bus.res_data}, 32'd1);
        check("post_rst_sel", {30'd0, bus.res_sel}, 32'd2);
        wait_idle();

        // 6: counter wrap (4-bit counter, 17 results)
        for (int i = 0; i < 16; i++) begin
            send(8'(i * 17), 8'(255 - i), 2'(i));
        end
        wait_idle();
        check("wrap_count", {28'd0, op_count}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
